// File: rtl/snake_tile_renderer.sv
// Snake tile renderer: maps VGA pixel coordinates onto a 32x24 grid of 20x20 tiles
// and emits RRRGGGBB colour through a two-strobe pipeline with matching sync delay.
module snake_tile_renderer (
    input  logic       clock,
    input  logic       clear,
    input  logic       pixEn,
    input  logic       hSyncIn,
    input  logic       vSyncIn,
    input  logic       brightIn,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    output logic [9:0] rdAddr,
    input  logic [1:0] rdData,
    output logic       hSync,
    output logic       vSync,
    output logic [7:0] rgb,
    output logic       frameTick
);
    localparam logic [9:0] H_VISIBLE = 10'd640;
    localparam logic [9:0] V_VISIBLE = 10'd480;
    localparam logic [9:0] V_TICK    = 10'd480;
    localparam logic [4:0] TILE_LAST = 5'd19;
    localparam logic [4:0] ROW_LAST  = 5'd23;
    localparam logic [4:0] COL_LAST  = 5'd31;

    localparam logic [7:0] C_BLANK  = 8'h00;
    localparam logic [7:0] C_BODY   = 8'h1C;
    localparam logic [7:0] C_HEAD   = 8'hFC;
    localparam logic [7:0] C_FOOD   = 8'hE0;
    localparam logic [7:0] C_BORDER = 8'h92;

    // Tile position counters and frame state
    logic [4:0] r_hPix;
    logic [4:0] r_col;
    logic [4:0] r_vPix;
    logic [4:0] r_row;
    logic [4:0] r_frameCnt;
    logic       r_synced;

    // Pipeline registers
    logic [9:0] r_rdAddr_p1;
    logic       r_hs_p1;
    logic       r_vs_p1;
    logic       r_vld_p1;
    logic       r_bd_p1;
    logic       r_hs_p2;
    logic       r_vs_p2;
    logic [7:0] r_rgb_p2;

    logic       w_hZero;
    logic       w_vZero;
    logic       w_visible;
    logic       w_syncNow;
    logic       w_border;
    logic       w_tick;
    logic [4:0] w_hPix;
    logic [4:0] w_col;
    logic [4:0] w_vPix;
    logic [4:0] w_row;

    function automatic logic [7:0] tile_colour(input logic       vld,
                                               input logic       border,
                                               input logic [1:0] code,
                                               input logic       blinkOff);
        logic [7:0] c;
        if (!vld)
            c = C_BLANK;
        else if (border)
            c = C_BORDER;
        else begin
            case (code)
                2'd1:    c = C_BODY;
                2'd2:    c = C_HEAD;
                2'd3:    c = blinkOff ? C_BLANK : C_FOOD;
                default: c = C_BLANK;
            endcase
        end
        return c;
    endfunction

    assign w_hZero   = (hCount == 10'd0);
    assign w_vZero   = (vCount == 10'd0);
    assign w_visible = (hCount < H_VISIBLE) && (vCount < V_VISIBLE);
    // Tile indices are trusted only once a frame origin has been seen since reset
    assign w_syncNow = r_synced || (w_hZero && w_vZero);
    assign w_tick    = pixEn && !clear && w_hZero && (vCount == V_TICK);
    assign w_hPix    = w_hZero ? 5'd0 : r_hPix;
    assign w_col     = w_hZero ? 5'd0 : r_col;
    assign w_border  = (w_row == 5'd0) || (w_row == ROW_LAST) ||
                       (w_col == 5'd0) || (w_col == COL_LAST);

    // Row tracking advances once per line, at the hCount=0 pixel
    always_comb begin
        w_vPix = r_vPix;
        w_row  = r_row;
        if (w_hZero) begin
            if (w_vZero) begin
                w_vPix = 5'd0;
                w_row  = 5'd0;
            end else if (r_vPix == TILE_LAST) begin
                w_vPix = 5'd0;
                w_row  = r_row + 5'd1;
            end else begin
                w_vPix = r_vPix + 5'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_hPix      <= '0;
            r_col       <= '0;
            r_vPix      <= '0;
            r_row       <= '0;
            r_frameCnt  <= '0;
            r_synced    <= 1'b0;
            r_rdAddr_p1 <= '0;
            r_hs_p1     <= 1'b1;
            r_vs_p1     <= 1'b1;
            r_vld_p1    <= 1'b0;
            r_bd_p1     <= 1'b0;
            r_hs_p2     <= 1'b1;
            r_vs_p2     <= 1'b1;
            r_rgb_p2    <= C_BLANK;
        end else if (pixEn) begin
            r_synced <= w_syncNow;
            if (w_hPix == TILE_LAST) begin
                r_hPix <= 5'd0;
                r_col  <= w_col + 5'd1;
            end else begin
                r_hPix <= w_hPix + 5'd1;
                r_col  <= w_col;
            end
            r_vPix <= w_vPix;
            r_row  <= w_row;
            if (w_tick)
                r_frameCnt <= r_frameCnt + 5'd1;

            // Stage 1: grid address and sideband capture
            r_rdAddr_p1 <= (w_visible && w_syncNow) ? {w_row, w_col} : 10'd0;
            r_hs_p1     <= hSyncIn;
            r_vs_p1     <= vSyncIn;
            r_vld_p1    <= brightIn && w_syncNow;
            r_bd_p1     <= w_border;

            // Stage 2: tile code resolved to colour
            r_hs_p2  <= r_hs_p1;
            r_vs_p2  <= r_vs_p1;
            r_rgb_p2 <= tile_colour(r_vld_p1, r_bd_p1, rdData, r_frameCnt[4]);
        end
    end

    assign rdAddr    = r_rdAddr_p1;
    assign hSync     = r_hs_p2;
    assign vSync     = r_vs_p2;
    assign rgb       = r_rgb_p2;
    assign frameTick = w_tick;

endmodule

// File: doc/snake_tile_renderer.md
SNAKE_TILE_RENDERER -- requirements
Module: snake_tile_renderer

Interface
REQ-001 SHALL have port: clock  input  1  system clock (100 MHz), sole clock domain.
REQ-002 SHALL have port: clear  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: pixEn  input  1  one-cycle pixel strobe; all pipeline state advances only on cycles with pixEn=1.
REQ-004 SHALL have port: hSyncIn  input  1  horizontal sync from the timing generator (active-low).
REQ-005 SHALL have port: vSyncIn  input  1  vertical sync from the timing generator (active-low).
REQ-006 SHALL have port: brightIn  input  1  visible-area flag from the timing generator.
REQ-007 SHALL have port: hCount  input  10  pixel column, 0..799; visible 0..639.
REQ-008 SHALL have port: vCount  input  10  pixel line, 0..524; visible 0..479.
REQ-009 SHALL have port: rdAddr  output  10  tile-grid read address {row[4:0], col[4:0]}.
REQ-010 SHALL have port: rdData  input  2  tile code from the grid RAM, valid one clock after rdAddr changes.
REQ-011 SHALL have port: hSync  output  1  delayed hSyncIn.
REQ-012 SHALL have port: vSync  output  1  delayed vSyncIn.
REQ-013 SHALL have port: rgb  output  8  pixel colour, RRRGGGBB.
REQ-014 SHALL have port: frameTick  output  1  one-clock pulse at the start of vertical blank.

Function
REQ-015 Tiles SHALL be 20x20 pixels; grid 32 columns x 24 rows; col = floor(hCount/20), row = floor(vCount/20).
REQ-016 col/row SHALL come from incremental counters (pixel-in-tile 0..19, tile index), resynchronised to 0 when hCount=0 / vCount=0; no divider.
REQ-017 Stage 1 (pixEn): rdAddr <= {row,col}; hSyncIn, vSyncIn, brightIn and the border flag captured.
REQ-018 Stage 2 (next pixEn): rdData sampled; rgb, hSync, vSync updated from stage-1 data.
REQ-019 Latency hCount/vCount -> rgb SHALL be exactly 2 pixEn strobes; hSync/vSync SHALL carry identical 2-strobe delay.
REQ-020 rdAddr SHALL be held at 0 while hCount>=640 or vCount>=480.
REQ-021 Tile codes: 0 empty -> 0x00; 1 body -> 0x1C; 2 head -> 0xFC; 3 food -> 0xE0 when frameCnt[4]=0, else 0x00 (blink).
REQ-022 Border tiles (row 0, row 23, col 0, col 31) SHALL render 0x92 regardless of rdData.
REQ-023 rgb SHALL be 0x00 whenever delayed brightIn=0 (overrides border and tile colour).
REQ-024 frameCnt (5-bit, internal) SHALL increment by 1 per frameTick, wrapping 31->0.
REQ-025 frameTick SHALL be 1 for exactly the clock on which pixEn=1, hCount=0 and vCount=480; else 0.
REQ-026 On clocks with pixEn=0, all outputs and internal state SHALL hold.
REQ-027 Out-of-range inputs (hCount>799, vCount>524) SHALL not corrupt counters beyond the next hCount=0 / vCount=0 resync.

Reset
REQ-028 While clear=1 at a clock edge: rgb=0x00, hSync=1, vSync=1, frameTick=0, rdAddr=0, frameCnt=0, tile counters=0, pipeline contents=blank; clear SHALL take priority over pixEn.
REQ-029 After clear deasserts mid-frame, rgb SHALL stay 0x00 until valid data has traversed both stages; correct tile indices from the next hCount=0 / vCount=0.

Verification
REQ-030 Bench: clear 2 cycles mid-line -> all outputs at REQ-028 values on the following edge; rgb=0x00 for the next 2 pixEn.
REQ-031 Bench: hCount=45, vCount=65 with pixEn -> rdAddr=0x062 (row 3, col 2); rdData=1 -> rgb=0x1C on the 2nd pixEn after.
REQ-032 Bench: hCount=0..19 on line 0 -> rgb=0x92 for all 20 pixels; hCount=640 -> rgb=0x00 two strobes later.
REQ-033 Bench: rdData=3 held, run 32 frames -> food pixel 0xE0 in frames 0-15, 0x00 in frames 16-31; frameTick counted 32 times, one clock wide.
REQ-034 Bench: hSyncIn low pulse 96 pixEn wide -> hSync low pulse 96 pixEn wide, delayed 2 strobes; pixEn gaps of 3 clocks -> no output change between strobes.
